// File: rtl/mux_regdst_pipe_pkg.sv
// rtl/mux_regdst_pipe_pkg.sv - shared state encoding, defaults and helpers for mux_regdst_pipe
package mux_regdst_pipe_pkg;

    // Skid buffer occupancy: no entry, main only, main plus skid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    // Data emitted when the selector points past the last input
    localparam int DEFAULT_OUT_DEF = 0;

    // Width of the out-of-range event counter
    localparam int ERR_COUNT_W = 8;

    // Saturating increment so the counter sticks at all-ones instead of wrapping
    function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] value);
        return (value == {ERR_COUNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/mux_nsel.sv
// rtl/mux_nsel.sv - combinational N-way selector with out-of-range flag
module mux_nsel #(
    parameter int N_IN   = 5,
    parameter int DATA_W = 5,
    parameter int SEL_W  = 3
) (
    input  logic [N_IN*DATA_W-1:0] data,
    input  logic [SEL_W-1:0]       sel,
    output logic [DATA_W-1:0]      selected,
    output logic                   out_of_range
);

    // Pick the addressed input; an out-of-range selector yields zero and the caller substitutes its default
    always_comb begin
        selected = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                selected = data[k*DATA_W +: DATA_W];
            end
        end
    end

    // One extra bit keeps the compare correct when N_IN equals 2^SEL_W
    assign out_of_range = ({1'b0, sel} >= (SEL_W + 1)'(N_IN));

endmodule

// File: rtl/mux_regdst_pipe.sv
// rtl/mux_regdst_pipe.sv - registered selector with a two-entry skid buffer and error counter
module mux_regdst_pipe
    import mux_regdst_pipe_pkg::*;
#(
    parameter int N_IN        = 5,
    parameter int DATA_W      = 5,
    parameter int SEL_W       = 3,
    parameter int DEFAULT_OUT = DEFAULT_OUT_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_IN*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ERR_COUNT_W-1:0] err_count
);

    state_t            state;
    state_t            state_next;
    logic              ready_q;

    logic [DATA_W-1:0] sel_data;
    logic              sel_oor;
    logic [DATA_W-1:0] new_data;
    logic              new_err;

    logic [DATA_W-1:0] main_data;
    logic              main_err;
    logic [DATA_W-1:0] skid_data;
    logic              skid_err;

    logic              accept;
    logic              drain;

    mux_nsel #(
        .N_IN   (N_IN),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_sel (
        .data         (in_data),
        .sel          (in_sel),
        .selected     (sel_data),
        .out_of_range (sel_oor)
    );

    // Selection is resolved at acceptance, so buffered entries already carry final data and error flag
    assign new_data = sel_oor ? DATA_W'(DEFAULT_OUT) : sel_data;
    assign new_err  = sel_oor;

    // in_ready already folds in flush, so a flush cycle can never accept
    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // State register; ready is precomputed from the next state so it never sees out_ready combinationally
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != ST_FULL);
        end
    end

    // Next-state logic; flush overrides every other event
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        state_next = ST_FULL;
                    end else if (!accept && drain) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_next = ST_ONE;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // Outputs: main always holds the oldest entry, so it feeds the downstream port directly
    always_comb begin
        out_valid = (state == ST_ONE) || (state == ST_FULL);
        in_ready  = ready_q && !flush;
        out_data  = main_data;
        out_err   = main_err;
    end

    // Entry storage: new data lands in main when main is free or being drained, otherwise in skid
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            main_data <= '0;
            main_err  <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else if (flush) begin
            main_data <= '0;
            main_err  <= 1'b0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_data <= new_data;
                        main_err  <= new_err;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_data <= new_data;
                        main_err  <= new_err;
                    end else if (accept) begin
                        skid_data <= new_data;
                        skid_err  <= new_err;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_data <= skid_data;
                        main_err  <= skid_err;
                    end
                end
                default: begin
                    main_data <= '0;
                    main_err  <= 1'b0;
                end
            endcase
        end
    end

    // Count every accepted out-of-range entry, even ones later flushed, saturating at the top
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (accept && sel_oor) begin
            err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_mux_regdst_pipe.sv
// tb/tb_mux_regdst_pipe.sv - self-checking bench for mux_regdst_pipe against a queue model
module tb_mux_regdst_pipe;

    localparam int N_IN   = 5;
    localparam int DATA_W = 5;
    localparam int SEL_W  = 3;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [N_IN*DATA_W-1:0] in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic                   flush;
    logic [DATA_W-1:0]      out_data;
    logic                   out_err;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             err_count;

    always #5 clk = ~clk;

    mux_regdst_pipe #(
        .N_IN   (N_IN),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_count (err_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int data;
        int err;
    } ent_t;

    ent_t q[$];
    int   m_cnt    = 0;
    bit   m_rdy_ok = 1'b0;

    localparam logic [24:0] BASIC_D = {5'd31, 5'd4, 5'd3, 5'd2, 5'd1};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive after the falling edge, compare against the model, then advance the model at the rising edge
    task automatic cycle(input bit v, input int s, input logic [24:0] d, input bit f, input bit ordy, input bit rn);
        ent_t e;
        bit   exp_ready;
        bit   exp_valid;
        bit   acc;
        bit   drn;
        @(negedge clk);
        in_valid  = v;
        in_sel    = SEL_W'(s);
        in_data   = d;
        flush     = f;
        out_ready = ordy;
        reset_n   = rn;
        #1;
        exp_valid = (q.size() > 0);
        exp_ready = m_rdy_ok && (q.size() < 2) && !f;
        check_eq("in_ready", in_ready, exp_ready);
        check_eq("out_valid", out_valid, exp_valid);
        check_eq("err_count", err_count, m_cnt);
        if (exp_valid) begin
            check_eq("out_data", out_data, q[0].data);
            check_eq("out_err", out_err, q[0].err);
        end
        @(posedge clk);
        if (!rn) begin
            q.delete();
            m_cnt    = 0;
            m_rdy_ok = 1'b0;
        end else begin
            acc = v && exp_ready;
            drn = exp_valid && ordy;
            if (f) begin
                q.delete();
            end else begin
                if (drn) void'(q.pop_front());
                if (acc) begin
                    e.err  = (s >= N_IN) ? 1 : 0;
                    e.data = (s >= N_IN) ? 0 : int'((d >> (s * DATA_W)) & 25'd31);
                    q.push_back(e);
                end
            end
            if (acc && s >= N_IN && m_cnt < 255) m_cnt++;
            m_rdy_ok = 1'b1;
        end
    endtask

    initial begin
        int saved;
        logic [24:0] rd;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);

        // Reset state
        cycle(0, 0, 25'd0, 0, 0, 0);
        #1;
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_err", out_err, 0);
        check_eq("rst_in_ready", in_ready, 0);
        cycle(0, 0, 25'd0, 0, 1, 1);

        // Basic select sweep
        for (int s = 0; s < N_IN; s++) cycle(1, s, BASIC_D, 0, 1, 1);
        cycle(0, 0, BASIC_D, 0, 1, 1);
        cycle(0, 0, BASIC_D, 0, 1, 1);

        // Out-of-range selectors
        for (int s = 5; s < 8; s++) cycle(1, s, BASIC_D, 0, 1, 1);
        cycle(0, 0, BASIC_D, 0, 1, 1);
        #1;
        check_eq("oor_count", err_count, 3);

        // Backpressure: third offer must wait
        cycle(1, 0, BASIC_D, 0, 0, 1);
        cycle(1, 1, BASIC_D, 0, 0, 1);
        cycle(1, 2, BASIC_D, 0, 0, 1);
        #1;
        check_eq("bp_ready_low", in_ready, 0);
        cycle(1, 2, BASIC_D, 0, 1, 1);
        cycle(1, 2, BASIC_D, 0, 1, 1);
        cycle(0, 0, BASIC_D, 0, 1, 1);
        cycle(0, 0, BASIC_D, 0, 1, 1);

        // Flush from FULL with a concurrent offer
        cycle(1, 0, BASIC_D, 0, 0, 1);
        cycle(1, 1, BASIC_D, 0, 0, 1);
        saved = m_cnt;
        cycle(1, 3, BASIC_D, 1, 0, 1);
        #1;
        check_eq("flush_valid", out_valid, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, BASIC_D, 0, 1, 1);
        #1;
        check_eq("flush_count", err_count, saved);

        // Reset while FULL with err_count at 4
        cycle(1, 5, BASIC_D, 0, 0, 1);
        cycle(1, 0, BASIC_D, 0, 0, 1);
        #1;
        check_eq("pre_rst_count", err_count, 4);
        cycle(0, 0, BASIC_D, 0, 0, 0);
        #1;
        check_eq("mid_rst_data", out_data, 0);
        check_eq("mid_rst_err", out_err, 0);
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_count", err_count, 0);
        cycle(0, 0, BASIC_D, 0, 1, 1);
        #1;
        check_eq("post_rst_ready", in_ready, 1);
        cycle(0, 0, BASIC_D, 0, 1, 1);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            rd = 25'($urandom);
            cycle(1, 7, rd, 0, 1, 1);
        end
        #1;
        check_eq("sat_count", err_count, 255);
        cycle(0, 0, 25'd0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rd = 25'($urandom);
            cycle(($urandom % 4) != 0, int'($urandom % 8), rd, ($urandom % 20) == 0,
                  ($urandom % 3) != 0, ($urandom % 100) != 0);
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 25'd0, 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
